// File: rtl/cache_mem_requester_pkg.sv
// Shared definitions for the cache miss requester: block size, address width, FSM state encoding.
// The optional writeback path is enabled by defining CACHE_WRITEBACK_EN.
package cache_mem_requester_pkg;

    localparam int unsigned Memory_Block_Size = 128;
    localparam int unsigned BLOCK_ADDR_W      = 10;
    localparam int unsigned TMR_W             = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WB      = 3'd1,
        ST_WB_HOLD = 3'd2,
        ST_RD      = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    function automatic logic [TMR_W-1:0] tmr_count(input int unsigned cycles);
        return TMR_W'(cycles);
    endfunction

endpackage

// File: rtl/cache_mem_requester_timer.sv
// mem_req_timer: loadable down-counter that only counts while enabled and flags its last counted cycle.
// Shared by the writeback and read phases of the requester.
module mem_req_timer
    import cache_mem_requester_pkg::*;
#(
    parameter int unsigned W = TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments and a synchronous reset checked first inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The edge that consumes the last remaining count is the terminal one.
    assign tc_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/cache_mem_requester.sv
// Cache-side initiator: optional dirty-victim writeback, then block fetch, returned as a one-cycle refill strobe.
// Writeback path compiled in only when CACHE_WRITEBACK_EN is defined; otherwise Wr and din are tied low.
module cache_mem_requester
    import cache_mem_requester_pkg::*;
#(
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned WR_CYCLES = 2,
    parameter int unsigned ADDR_W    = BLOCK_ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         miss_req,
    input  logic [ADDR_W-1:0]            miss_addr,
    input  logic                         victim_dirty,
    input  logic [ADDR_W-1:0]            victim_addr,
    input  logic [Memory_Block_Size-1:0] victim_data,
    output logic                         refill_valid,
    output logic [Memory_Block_Size-1:0] refill_data,
    output logic                         busy,
    output logic [15:0]                  miss_count,
    output logic                         Req_Low,
    output logic [ADDR_W-1:0]            addr,
    output logic [Memory_Block_Size-1:0] din,
    output logic                         Wr,
    input  logic [Memory_Block_Size-1:0] dout,
    input  logic                         Rdy_Low
);

    localparam logic [TMR_W-1:0] RD_LOAD = tmr_count(RD_LAT);

    state_e                         state_q;
    logic [ADDR_W-1:0]              miss_addr_q;
    logic [ADDR_W-1:0]              addr_q;
    logic [Memory_Block_Size-1:0]   refill_data_q;
    logic                           refill_valid_q;
    logic                           busy_q;
    logic                           req_low_q;
    logic [15:0]                    miss_count_q;
    logic [15:0]                    miss_count_d;

    logic                           accept;
    logic                           go_wb;
    logic                           tmr_load;
    logic [TMR_W-1:0]               tmr_load_val;
    logic                           tmr_en;
    logic                           tmr_tc;

    assign accept       = (state_q == ST_IDLE) && miss_req;
    assign miss_count_d = miss_count_q + 16'd1;

`ifdef CACHE_WRITEBACK_EN
    localparam logic [TMR_W-1:0] WR_LOAD = tmr_count(WR_CYCLES);

    logic                         wr_q;
    logic [Memory_Block_Size-1:0] din_q;

    assign go_wb        = victim_dirty;
    // The read count is reloaded during WB_HOLD, where the timer is idle.
    assign tmr_load     = accept || (state_q == ST_WB_HOLD);
    assign tmr_load_val = (accept && victim_dirty) ? WR_LOAD : RD_LOAD;
    assign tmr_en       = ((state_q == ST_WB) || (state_q == ST_RD)) && !Rdy_Low;
    assign Wr           = wr_q;
    assign din          = din_q;
`else
    logic unused_victim;

    assign go_wb         = 1'b0;
    assign tmr_load      = accept;
    assign tmr_load_val  = RD_LOAD;
    assign tmr_en        = (state_q == ST_RD) && !Rdy_Low;
    assign Wr            = 1'b0;
    assign din           = '0;
    assign unused_victim = ^{victim_dirty, victim_data, WR_CYCLES};
`endif

    mem_req_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .tc_o       (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            miss_addr_q    <= '0;
            addr_q         <= '0;
            refill_data_q  <= '0;
            refill_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            req_low_q      <= 1'b1;
            miss_count_q   <= '0;
`ifdef CACHE_WRITEBACK_EN
            wr_q           <= 1'b0;
            din_q          <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (miss_req) begin
                        miss_addr_q  <= miss_addr;
                        miss_count_q <= miss_count_d;
                        busy_q       <= 1'b1;
                        req_low_q    <= 1'b0;
                        state_q      <= go_wb ? ST_WB : ST_RD;
                        addr_q       <= go_wb ? victim_addr : miss_addr;
`ifdef CACHE_WRITEBACK_EN
                        wr_q         <= victim_dirty;
                        if (victim_dirty) begin
                            din_q <= victim_data;
                        end
`endif
                    end
                end
`ifdef CACHE_WRITEBACK_EN
                ST_WB: begin
                    if (tmr_tc) begin
                        state_q   <= ST_WB_HOLD;
                        req_low_q <= 1'b1;
                        wr_q      <= 1'b0;
                    end
                end
                ST_WB_HOLD: begin
                    // addr/din keep the victim values here; memory registers Wr one cycle late.
                    state_q   <= ST_RD;
                    req_low_q <= 1'b0;
                    addr_q    <= miss_addr_q;
                end
`endif
                ST_RD: begin
                    if (tmr_tc) begin
                        state_q        <= ST_DONE;
                        refill_data_q  <= dout;
                        refill_valid_q <= 1'b1;
                        req_low_q      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q        <= ST_IDLE;
                    refill_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                end
                default: begin
                    state_q        <= ST_IDLE;
                    refill_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                    req_low_q      <= 1'b1;
                end
            endcase
        end
    end

    assign refill_valid = refill_valid_q;
    assign refill_data  = refill_data_q;
    assign busy         = busy_q;
    assign miss_count   = miss_count_q;
    assign Req_Low      = req_low_q;
    assign addr         = addr_q;

endmodule
